// File: rtl/dmem_arbiter.sv
// Two-port arbiter and one-cycle access sequencer in front of the shared data memory.
// Port 0 has priority; port 1 is protected from starvation by a saturating wait counter.
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned WAIT_W   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_ack,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_ack,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int unsigned DW = 32;

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_grant;
  logic                w_sel1;
  logic                w_p0_v;
  logic                w_p1_v;
  logic                w_access;
  logic                w_cnt_max;

  logic                r_owner;
  logic                r_we;
  logic                r_mis;
  logic [DW-1:0]       r_addr;
  logic [DW-1:0]       r_wdata;
  logic [WAIT_W-1:0]   r_wait_cnt;

  logic                r_p0_ack;
  logic                r_p1_ack;
  logic                r_p0_err;
  logic                r_p1_err;
  logic [DW-1:0]       r_p0_rdata;
  logic [DW-1:0]       r_p1_rdata;

  // A port being acked this cycle still holds its request; mask it to avoid a re-grant.
  assign w_p0_v    = p0_req & ~r_p0_ack;
  assign w_p1_v    = p1_req & ~r_p1_ack;
  assign w_cnt_max = (r_wait_cnt == WAIT_W'(MAX_WAIT));
  assign w_access  = (r_state == S_ACCESS);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_sel1      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_p0_v | w_p1_v) begin
          w_grant     = 1'b1;
          w_sel1      = w_p1_v & (~w_p0_v | w_cnt_max);
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Request latch and starvation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner    <= 1'b0;
      r_we       <= 1'b0;
      r_mis      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wait_cnt <= '0;
    end else if (w_grant) begin
      r_owner <= w_sel1;
      r_we    <= w_sel1 ? p1_we    : p0_we;
      r_addr  <= w_sel1 ? p1_addr  : p0_addr;
      r_wdata <= w_sel1 ? p1_wdata : p0_wdata;
      r_mis   <= w_sel1 ? (p1_addr[1:0] != 2'b00) : (p0_addr[1:0] != 2'b00);
      if (w_sel1)
        r_wait_cnt <= '0;
      else if (w_p1_v && !w_cnt_max)
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end
  end

  // Completion: one-cycle ack/err pulse to the owner, read data captured for aligned reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p0_ack   <= 1'b0;
      r_p1_ack   <= 1'b0;
      r_p0_err   <= 1'b0;
      r_p1_err   <= 1'b0;
      r_p0_rdata <= '0;
      r_p1_rdata <= '0;
    end else begin
      r_p0_ack <= 1'b0;
      r_p1_ack <= 1'b0;
      r_p0_err <= 1'b0;
      r_p1_err <= 1'b0;
      if (w_access) begin
        if (r_owner) begin
          r_p1_ack <= 1'b1;
          r_p1_err <= r_mis;
          if (!r_we && !r_mis) r_p1_rdata <= mem_rdata;
        end else begin
          r_p0_ack <= 1'b1;
          r_p0_err <= r_mis;
          if (!r_we && !r_mis) r_p0_rdata <= mem_rdata;
        end
      end
    end
  end

  // Strobes are gated by rst so a reset landing on ACCESS cannot commit a write.
  assign mem_read  = w_access & ~r_we & ~r_mis & ~rst;
  assign mem_write = w_access &  r_we & ~r_mis & ~rst;
  assign mem_addr  = w_access ? r_addr  : '0;
  assign mem_wdata = w_access ? r_wdata : '0;
  assign busy      = w_access;

  assign p0_ack   = r_p0_ack;
  assign p1_ack   = r_p1_ack;
  assign p0_err   = r_p0_err;
  assign p1_err   = r_p1_err;
  assign p0_rdata = r_p0_rdata;
  assign p1_rdata = r_p1_rdata;

endmodule
